// File: rtl/wb_spram_burst_pkg.sv
// Shared Wishbone cycle/burst type codes and slave state encoding for wb_spram_burst.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

endpackage

// File: rtl/wb_spram_burst_addr_gen.sv
// Next-beat word address and range flag for constant, linear and wrapping bursts.
module wb_burst_addr_gen
  import wb_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic [AW-1:0] ack_addr,
  input  logic [2:0]    cti,
  input  logic [1:0]    bte,
  output logic [AW-1:0] next_addr,
  output logic          next_inrange
);

  logic [AW:0]   lin;
  logic [AW-1:0] wmask;

  assign lin = {1'b0, ack_addr} + (AW+1)'(1);

  always_comb begin
    unique case (bte)
      BTE_WRAP4:  wmask = AW'(3);
      BTE_WRAP8:  wmask = AW'(7);
      BTE_WRAP16: wmask = AW'(15);
      default:    wmask = '0;
    endcase
  end

  // A linear step off the top of the RAM is reported, never wrapped to word 0.
  always_comb begin
    next_addr    = ack_addr;
    next_inrange = 1'b1;
    if (cti == CTI_INCR) begin
      if (bte == BTE_LINEAR) begin
        next_addr    = lin[AW-1:0];
        next_inrange = ~lin[AW];
      end else begin
        next_addr = (ack_addr & ~wmask) | (lin[AW-1:0] & wmask);
      end
    end
  end

endmodule

// File: rtl/wb_spram_burst.sv
// Wishbone B4 registered-feedback burst slave over a byte-laned single-port RAM.
// Optional beat/error counters enabled by defining WB_SPRAM_BURST_STATS_EN.
module wb_spram_burst
  import wb_pkg::*;
#(
  parameter logic [31:0] WBA   = 32'h0000_0000,
  parameter int unsigned WS_P2 = 10,
  parameter int unsigned DW    = 32
) (
  input  logic            CLK,
  input  logic            RST_SYNC,
  input  logic [31:0]     WB_ADR_IN,
  input  logic            WB_CYC_IN,
  input  logic            WB_STB_IN,
  input  logic            WB_WE_IN,
  input  logic [DW/8-1:0] WB_SEL_IN,
  input  logic [2:0]      WB_CTI_IN,
  input  logic [1:0]      WB_BTE_IN,
  input  logic [DW-1:0]   WB_WR_DAT_IN,
  output logic            WB_ACK_OUT,
  output logic            WB_ERR_OUT,
  output logic            WB_STALL_OUT,
  output logic [DW-1:0]   WB_RD_DAT_OUT
`ifdef WB_SPRAM_BURST_STATS_EN
  ,
  output logic [31:0]     STAT_RD_BEATS,
  output logic [31:0]     STAT_WR_BEATS,
  output logic [31:0]     STAT_ERRS
`endif
);

  localparam int unsigned NB        = DW / 8;
  localparam int unsigned LB        = $clog2(NB);
  localparam int unsigned AW        = WS_P2 - LB;
  localparam int unsigned RAM_WORDS = 1 << AW;

  state_t        state;
  logic          ack;
  logic          err;
  logic [AW-1:0] ack_addr;
  logic [AW-1:0] nxt_addr;
  logic          nxt_inrange;
  logic [AW-1:0] ram_addr;
  logic [31:0]   off;
  logic [AW-1:0] adr_word;
  logic          adr_inrange;
  logic          req;
  logic          burst_cont;
  logic          wr_en;

  assign req         = WB_CYC_IN & WB_STB_IN;
  assign off         = WB_ADR_IN - WBA;
  assign adr_inrange = (off >> WS_P2) == '0;
  assign adr_word    = off[WS_P2-1:LB];
  assign burst_cont  = req && (WB_CTI_IN == CTI_CONST || WB_CTI_IN == CTI_INCR);
  assign wr_en       = ack && req && WB_WE_IN && !RST_SYNC;

  wb_burst_addr_gen #(.AW(AW)) u_addr_gen (
    .ack_addr     (ack_addr),
    .cti          (WB_CTI_IN),
    .bte          (WB_BTE_IN),
    .next_addr    (nxt_addr),
    .next_inrange (nxt_inrange)
  );

  // One RAM port: writes use the beat being acked, reads look ahead one beat.
  assign ram_addr = wr_en ? ack_addr : ((state == IDLE) ? adr_word : nxt_addr);

  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      state    <= IDLE;
      ack      <= 1'b0;
      err      <= 1'b0;
      ack_addr <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && !ack && !err) begin
            ack_addr <= adr_word;
            if (adr_inrange) begin
              ack   <= 1'b1;
              state <= BURST;
            end else begin
              err <= 1'b1;
            end
          end
        end
        BURST: begin
          if (ack && burst_cont) begin
            ack_addr <= nxt_addr;
            if (nxt_inrange) begin
              ack <= 1'b1;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic [7:0] mem [0:RAM_WORDS-1];
    logic [7:0] rd_q;
    always_ff @(posedge CLK) begin
      if (wr_en && WB_SEL_IN[g]) mem[ram_addr] <= WB_WR_DAT_IN[8*g +: 8];
      rd_q <= mem[ram_addr];
    end
    assign WB_RD_DAT_OUT[8*g +: 8] = rd_q;
  end

  assign WB_ACK_OUT   = ack;
  assign WB_ERR_OUT   = err;
  assign WB_STALL_OUT = 1'b0;

`ifdef WB_SPRAM_BURST_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      STAT_RD_BEATS <= '0;
      STAT_WR_BEATS <= '0;
      STAT_ERRS     <= '0;
    end else begin
      if (ack && req && !WB_WE_IN && STAT_RD_BEATS != '1) STAT_RD_BEATS <= STAT_RD_BEATS + 32'd1;
      if (wr_en && STAT_WR_BEATS != '1)                    STAT_WR_BEATS <= STAT_WR_BEATS + 32'd1;
      if (err && STAT_ERRS != '1)                          STAT_ERRS     <= STAT_ERRS + 32'd1;
    end
  end
`endif

endmodule
